// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, scoreboard entry type and Tnew ageing helper for hazard_scoreboard.
package hazard_pkg;

  localparam int unsigned HZ_AW = 5;
  localparam int unsigned HZ_TW = 3;

  localparam logic [HZ_TW-1:0] TUSE_NONE   = '1;
  localparam logic [HZ_TW-1:0] TUSE_BRANCH = 3'd0;
  localparam logic [HZ_TW-1:0] TUSE_ALU    = 3'd1;
  localparam logic [HZ_TW-1:0] TUSE_STORE  = 3'd2;
  localparam logic [HZ_TW-1:0] TNEW_ALU    = 3'd1;
  localparam logic [HZ_TW-1:0] TNEW_LOAD   = 3'd2;
  localparam logic [HZ_TW-1:0] TNEW_MFC0   = 3'd2;
  localparam logic [HZ_TW-1:0] TNEW_MFHILO = 3'd1;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic             valid;
    logic [HZ_AW-1:0] wa;
    logic [HZ_TW-1:0] tnew;
    logic             epc;
  } hz_entry_t;

  // One stage closer to write-back: Tnew counts down and sticks at zero.
  function automatic logic [HZ_TW-1:0] tnew_age(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - HZ_TW'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md.sv
// md_busy_counter: mult/div busy counter, reloaded on every start and counting down to idle.
module md_busy_counter #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall/forward unit over a scoreboard of in-flight GPR writes.
// Define HAZARD_PERF_EN to build the 32-bit stall-cycle performance counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_AW     = HZ_AW,
  parameter int unsigned TNEW_W     = HZ_TW,
  parameter int unsigned MULT_LAT   = 5,
  parameter int unsigned DIV_LAT    = 10
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_SRC*REG_AW-1:0]                  ra_d,
  input  logic [NUM_SRC*TNEW_W-1:0]                  tuse_d,
  input  logic                                       issue_we,
  input  logic [REG_AW-1:0]                          issue_wa,
  input  logic [TNEW_W-1:0]                          issue_tnew,
  input  logic                                       issue_mtc0_epc,
  input  logic                                       eret_d,
  input  logic                                       md_use_d,
  input  logic                                       md_start,
  input  logic                                       md_is_div,
  input  logic                                       flush,
  output logic                                       stall,
  output logic                                       stall_data,
  output logic                                       stall_md,
  output logic                                       stall_eret,
  output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]    fwd_sel,
  output logic                                       md_busy,
  output logic [31:0]                                perf_stall_cnt
);

  localparam int unsigned FW = $clog2(NUM_STAGES + 1);

  hz_entry_t         ent   [NUM_STAGES];
  hz_entry_t         aged  [NUM_STAGES-1];
  hz_entry_t         issue_ent;
  logic [REG_AW-1:0] ra    [NUM_SRC];
  logic [TNEW_W-1:0] tuse  [NUM_SRC];
  logic              hit;
  logic [TNEW_W-1:0] m_tnew;
  logic [FW-1:0]     m_idx;
  logic              any_epc;

  // Entry written into E by the instruction leaving D.
  always_comb begin
    issue_ent       = '0;
    issue_ent.valid = issue_we && (issue_wa != '0);
    issue_ent.wa    = issue_wa;
    issue_ent.tnew  = issue_tnew;
    issue_ent.epc   = issue_mtc0_epc;
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      aged[k]      = ent[k];
      aged[k].tnew = tnew_age(ent[k].tnew);
    end
  end

  // Scoreboard shift register; a stalled D inserts a bubble into E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) ent[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_STAGES; k++) ent[k] <= '0;
    end else begin
      ent[0] <= stall ? '0 : issue_ent;
      for (int k = 1; k < NUM_STAGES; k++) ent[k] <= aged[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ra[i]   = ra_d[i*REG_AW +: REG_AW];
      tuse[i] = tuse_d[i*TNEW_W +: TNEW_W];
    end
  end

  // Youngest matching entry wins: scan oldest to youngest so the youngest overwrites.
  always_comb begin
    stall_data = 1'b0;
    fwd_sel    = '0;
    hit        = 1'b0;
    m_tnew     = '0;
    m_idx      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit    = 1'b0;
      m_tnew = '0;
      m_idx  = FW'(FWD_RF);
      for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
        if (ent[k].valid && (ent[k].wa == ra[i])) begin
          hit    = 1'b1;
          m_tnew = ent[k].tnew;
          m_idx  = FW'(k + 1);
        end
      end
      if (hit && (ra[i] != '0)) begin
        if ((tuse[i] != TUSE_NONE) && (m_tnew > tuse[i])) stall_data = 1'b1;
        if (m_tnew == '0) fwd_sel[i*FW +: FW] = m_idx;
      end
    end
  end

  always_comb begin
    any_epc = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) any_epc = any_epc | ent[k].epc;
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .start   (md_start),
    .is_div  (md_is_div),
    .md_busy (md_busy)
  );

  assign stall_md   = md_use_d && (md_busy || md_start);
  assign stall_eret = eret_d && any_epc;
  assign stall      = stall_data || stall_md || stall_eret;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'd0;
    end else if (stall && !flush) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table vectors, directed multi-cycle sequences and a random run against a reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra_d;
  logic [5:0]  tuse_d;
  logic        issue_we;
  logic [4:0]  issue_wa;
  logic [2:0]  issue_tnew;
  logic        issue_mtc0_epc, eret_d, md_use_d, md_start, md_is_div, flush;
  logic        stall, stall_data, stall_md, stall_eret, md_busy;
  logic [3:0]  fwd_sel;
  logic [31:0] perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .ra_d           (ra_d),
    .tuse_d         (tuse_d),
    .issue_we       (issue_we),
    .issue_wa       (issue_wa),
    .issue_tnew     (issue_tnew),
    .issue_mtc0_epc (issue_mtc0_epc),
    .eret_d         (eret_d),
    .md_use_d       (md_use_d),
    .md_start       (md_start),
    .md_is_div      (md_is_div),
    .flush          (flush),
    .stall          (stall),
    .stall_data     (stall_data),
    .stall_md       (stall_md),
    .stall_eret     (stall_eret),
    .fwd_sel        (fwd_sel),
    .md_busy        (md_busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [2:0] tn;
    logic [4:0] ra0;
    logic [2:0] tu0;
    logic [4:0] ra1;
    logic [2:0] tu1;
    logic       e_sd;
    logic [3:0] e_fwd;
  } vec_t;

  vec_t tbl [15];

  // Reference model: each slot keeps the instruction as issued; its Tnew is derived from its age.
  bit mv   [3];
  int mwa  [3];
  int mtn  [3];
  bit mepc [3];
  int mcyc, mend, mperf;

  function automatic vec_t mk(input logic we, input int wa, input int tn, input int ra0, input int tu0,
                              input int ra1, input int tu1, input logic esd, input int efwd);
    vec_t v;
    v.we = we; v.wa = 5'(wa); v.tn = 3'(tn);
    v.ra0 = 5'(ra0); v.tu0 = 3'(tu0); v.ra1 = 5'(ra1); v.tu1 = 3'(tu1);
    v.e_sd = esd; v.e_fwd = 4'(efwd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ra_d = '0; tuse_d = 6'h3f;
    issue_we = 1'b0; issue_wa = '0; issue_tnew = '0; issue_mtc0_epc = 1'b0;
    eret_d = 1'b0; md_use_d = 1'b0; md_start = 1'b0; md_is_div = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int cnt;
    logic [8:0] ex;

    tbl[0]  = mk(0, 0, 0, 0, 7, 0, 7, 0, 0);
    tbl[1]  = mk(1, 3, 2, 0, 7, 0, 7, 0, 0);
    tbl[2]  = mk(1, 4, 1, 3, 1, 0, 7, 1, 0);
    tbl[3]  = mk(1, 4, 1, 3, 1, 0, 7, 0, 0);
    tbl[4]  = mk(0, 0, 0, 3, 0, 4, 0, 1, 4'b0011);
    tbl[5]  = mk(0, 0, 0, 3, 0, 4, 0, 0, 4'b1000);
    tbl[6]  = mk(1, 5, 1, 0, 7, 0, 7, 0, 0);
    tbl[7]  = mk(1, 5, 2, 0, 7, 0, 7, 0, 0);
    tbl[8]  = mk(0, 0, 0, 5, 0, 0, 7, 1, 0);
    tbl[9]  = mk(0, 0, 0, 5, 0, 0, 7, 1, 0);
    tbl[10] = mk(0, 0, 0, 5, 0, 0, 7, 0, 4'b0011);
    tbl[11] = mk(1, 6, 2, 0, 7, 0, 7, 0, 0);
    tbl[12] = mk(0, 0, 0, 6, 7, 0, 7, 0, 0);
    tbl[13] = mk(1, 0, 2, 0, 7, 0, 7, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 6, 0, 0, 4'b1100);

    reset = 1'b0;
    idle();
    #2;
    check("reset_outs", 32'({stall, stall_data, stall_md, stall_eret, md_busy, fwd_sel}), 32'd0);
    check("reset_perf", perf_stall_cnt, 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Table: GPR RAW stalls, forwarding, youngest-match priority, Tuse none and $0.
    for (int r = 0; r < 15; r++) begin
      idle();
      issue_we = tbl[r].we; issue_wa = tbl[r].wa; issue_tnew = tbl[r].tn;
      ra_d = {tbl[r].ra1, tbl[r].ra0};
      tuse_d = {tbl[r].tu1, tbl[r].tu0};
      #1;
      check($sformatf("tbl%0d_stall_data", r), 32'(stall_data), 32'(tbl[r].e_sd));
      check($sformatf("tbl%0d_fwd_sel", r), 32'(fwd_sel), 32'(tbl[r].e_fwd));
      check($sformatf("tbl%0d_stall", r), 32'(stall), 32'(tbl[r].e_sd));
      tick();
    end

    // Muldiv interlock length: div then mult.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      md_start = 1'b1; md_is_div = (t == 0); md_use_d = 1'b1;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
        #1;
        if (stall_md) cnt++;
        tick();
        md_start = 1'b0;
      end
      check(t == 0 ? "div_stall_cycles" : "mult_stall_cycles", 32'(cnt), t == 0 ? 32'd11 : 32'd6);
      check("md_busy_idle", 32'(md_busy), 32'd0);
    end

    // mtc0 EPC followed by eret.
    do_reset();
    issue_mtc0_epc = 1'b1;
    tick();
    issue_mtc0_epc = 1'b0; eret_d = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (stall_eret) cnt++;
      tick();
    end
    check("eret_stall_cycles", 32'(cnt), 32'd3);

    // Flush while a load is in E and D is stalled on it; the muldiv counter keeps running.
    do_reset();
    md_start = 1'b1; md_is_div = 1'b1;
    issue_we = 1'b1; issue_wa = 5'd3; issue_tnew = 3'd2;
    tick();
    idle();
    ra_d[4:0] = 5'd3; tuse_d[2:0] = 3'd0; flush = 1'b1;
    #1;
    check("flush_pre_stall", 32'(stall_data), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("flush_post_stall", 32'(stall_data), 32'd0);
    check("flush_md_busy", 32'(md_busy), 32'd1);

    // Seven counted stall cycles, then one stalled flush cycle that is not counted.
    do_reset();
    md_start = 1'b1; md_is_div = 1'b1; md_use_d = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      md_start = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("perf_flush_stall", 32'(stall), 32'd1);
    tick();
    idle();
    #1;
`ifdef HAZARD_PERF_EN
    check("perf_count", perf_stall_cnt, 32'd7);
`else
    check("perf_count", perf_stall_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of a stall clears everything at once.
    do_reset();
    md_start = 1'b1; issue_we = 1'b1; issue_wa = 5'd3; issue_tnew = 3'd2;
    tick();
    idle();
    ra_d[4:0] = 5'd3; tuse_d[2:0] = 3'd0; md_use_d = 1'b1;
    #1;
    check("midrst_pre_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_outs", 32'({stall, stall_data, stall_md, stall_eret, md_busy, fwd_sel}), 32'd0);
    check("midrst_perf", perf_stall_cnt, 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Random run against the reference model.
    do_reset();
    for (int k = 0; k < 3; k++) begin mv[k] = 0; mwa[k] = 0; mtn[k] = 0; mepc[k] = 0; end
    mcyc = 0; mend = -1; mperf = 0;
    for (int n = 0; n < 400; n++) begin
      automatic int  r_ra [2];
      automatic int  r_tu [2];
      automatic int  fw   [2];
      automatic bit  e_sd, e_md, e_er, e_st, busy, found;
      automatic int  eff;
      for (int i = 0; i < 2; i++) begin
        r_ra[i] = $urandom_range(0, 7);
        r_tu[i] = $urandom_range(0, 7);
        ra_d[i*5 +: 5] = 5'(r_ra[i]);
        tuse_d[i*3 +: 3] = 3'(r_tu[i]);
      end
      issue_we       = 1'($urandom_range(0, 1));
      issue_wa       = 5'($urandom_range(0, 7));
      issue_tnew     = 3'($urandom_range(0, 3));
      issue_mtc0_epc = ($urandom_range(0, 9) == 0);
      eret_d         = ($urandom_range(0, 3) == 0);
      md_use_d       = ($urandom_range(0, 3) == 0);
      md_start       = ($urandom_range(0, 11) == 0);
      md_is_div      = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 19) == 0);
      #1;
      e_sd = 0;
      for (int i = 0; i < 2; i++) begin
        fw[i] = 0;
        found = 0;
        for (int k = 0; k < 3; k++) begin
          if (!found && mv[k] && mwa[k] == r_ra[i] && r_ra[i] != 0) begin
            found = 1;
            eff = (mtn[k] > k) ? mtn[k] - k : 0;
            if (r_tu[i] != 7 && eff > r_tu[i]) e_sd = 1;
            if (eff == 0) fw[i] = k + 1;
          end
        end
      end
      busy = (mcyc <= mend);
      e_md = md_use_d && (busy || md_start);
      e_er = eret_d && (mepc[0] || mepc[1] || mepc[2]);
      e_st = e_sd || e_md || e_er;
      ex = {e_st, e_sd, e_md, e_er, busy, 2'(fw[1]), 2'(fw[0])};
      check($sformatf("rnd%0d_outs", n),
            32'({stall, stall_data, stall_md, stall_eret, md_busy, fwd_sel}), 32'(ex));
      if (md_start) mend = mcyc + (md_is_div ? 10 : 5);
      mcyc++;
      if (e_st && !flush) mperf++;
      if (flush) begin
        for (int k = 0; k < 3; k++) begin mv[k] = 0; mwa[k] = 0; mtn[k] = 0; mepc[k] = 0; end
      end else begin
        for (int k = 2; k > 0; k--) begin
          mv[k] = mv[k-1]; mwa[k] = mwa[k-1]; mtn[k] = mtn[k-1]; mepc[k] = mepc[k-1];
        end
        if (e_st) begin
          mv[0] = 0; mwa[0] = 0; mtn[0] = 0; mepc[0] = 0;
        end else begin
          mv[0] = issue_we && issue_wa != 0; mwa[0] = int'(issue_wa);
          mtn[0] = int'(issue_tnew); mepc[0] = issue_mtc0_epc;
        end
      end
      tick();
    end
    idle();
    #1;
`ifdef HAZARD_PERF_EN
    check("rnd_perf", perf_stall_cnt, 32'(mperf));
`else
    check("rnd_perf", perf_stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
